weight_fetch_ctrl: RTL and testbench
====================================

// Module: weight_fetch_ctrl
// PURPOSE
//  Sequencer and arbiter for the 60x10b weight RAM. After reset it pulses the RAM init strobe.
//  On Start it fetches NUM_ROWS weight rows (10 words each) and hands each row to the neuron
//  datapath over a valid/ready handshake. Between reads it grants trainer write-back requests.
//  Sits between the weight RAM, the neuron MAC array and the weight-update (trainer) block.
// PARAMETERS
//  WIDTH     10  bits per weight word
//  LANES     10  words per row (RAM reads/writes LANES consecutive addresses)
//  DEPTH     60  RAM depth in words
//  ADDR_W    6   RAM address width
//  NUM_ROWS  3   rows per fetch pass. Constraint: NUM_ROWS*LANES <= DEPTH.
//                Row r occupies RAM addresses r*LANES .. r*LANES+LANES-1.
// PORTS
//  Clock    in   1             rising-edge clock
//  Reset    in   1             synchronous, active-high reset
//  Start    in   1             begin fetch pass; sampled only in IDLE
//  Busy     out  1             high from the cycle after Start is accepted until DONE ends
//  Done     out  1             one-cycle pulse after the last row handshake
//  RamInit  out  1             drives RAM init strobe (In)
//  RamWE    out  1             RAM write enable; 0 = RAM read
//  RamAddr  out  ADDR_W        RAM base address (row*LANES)
//  RamD     out  LANES*WIDTH   write data; lane i = [i*WIDTH +: WIDTH] -> RAM D[i]
//  RamQ     in   LANES*WIDTH   RAM read data, same packing; registered in RAM (1-cycle latency)
//  WValid   out  1             row data valid to datapath
//  WReady   in   1             datapath accepts row
//  WRow     out  3             index of the presented row
//  WData    out  LANES*WIDTH   presented row (= RamQ)
//  WrReq    in   1             trainer write request; level, held until WrAck
//  WrRow    in   3             target row of the write
//  WrData   in   LANES*WIDTH   write data, same packing
//  WrAck    out  1             one-cycle pulse: write done or rejected
//  WrErr    out  1             with WrAck: WrRow >= NUM_ROWS, no write performed
// BEHAVIOUR
//  Reset: state=INIT, row=0. Every output is 0 while Reset is high.
//  The RAM reads RAM[RamAddr..] into Q on every cycle with RamWE=0 and RamInit=0.
//  A write cycle leaves Q unchanged.
//  States:
//   INIT     RamInit=1 for exactly one cycle (the first cycle after Reset falls) -> IDLE.
//            Start and WrReq are ignored.
//   IDLE     RamAddr=0. Start=1 -> RD_ISSUE with row=0 and Busy=1.
//   RD_ISSUE RamAddr=row*LANES, RamWE=0; no write grant. Next cycle -> RD_VALID.
//   RD_VALID WValid=1, WRow=row, WData=RamQ. RamAddr is held at row*LANES, so Q re-reads the
//            same row and stays stable. On WValid&WReady at the clock edge: if row==NUM_ROWS-1,
//            go to DONE; otherwise row+1 and go to RD_ISSUE. Minimum 2 cycles per row.
//   DONE     Done=1 for one cycle, Busy=0 from the next cycle -> IDLE.
//  Write grant (combinational, same cycle as WrAck), allowed in IDLE, RD_VALID and DONE:
//   - WrRow >= NUM_ROWS: WrAck=1, WrErr=1, RamWE=0.
//   - RD_VALID with WrRow==row (hazard): grant deferred until the state leaves RD_VALID.
//   - Otherwise: RamWE=1, RamAddr=WrRow*LANES, RamD=WrData, WrAck=1. In RD_VALID the RAM
//     address returns to row*LANES next cycle. WValid stays high and WData is unchanged,
//     because Q holds during a write.
//   - At most one write per cycle. A requester holding WrReq high gets one grant per cycle.
//  Reads cannot starve: RD_ISSUE always wins, and writes never block a handshake.
//  WValid drops only after a handshake; WRow/WData must not change while WValid=1 && !WReady.
//  Start while Busy is ignored. Reset mid-pass aborts it, re-enters INIT and re-pulses RamInit,
//  which restores the default weights.
// TESTING
//  1 Reset 3 cycles, then release -> RamInit=1 for exactly 1 cycle; Busy/WValid/WrAck/Done=0.
//  2 Start with WReady=1 -> RamAddr 0,10,20; WValid rows 0,1,2 two cycles apart; Done 1 cycle
//    after row 2. Row0 lanes alternate 0x2AA/0x155; row1 all 0x155; row2 all 0x3E0.
//  3 WReady=0 for 5 cycles on row 1 -> WValid, WRow=1, RamAddr=10 and WData stay stable;
//    handshake on the 6th cycle.
//  4 During row-0 presentation, WrReq row 2 with all lanes 0x3FF -> WrAck in the same cycle,
//    RamWE=1, RamAddr=20; row 2 later presents 0x3FF.
//    WrReq row 0 during row-0 presentation -> WrAck only after the row-0 handshake.
//  5 WrReq with WrRow=5 (NUM_ROWS=3) -> WrAck=1, WrErr=1, RamWE never asserted.
//  6 Reset during RD_VALID of row 1 -> all outputs 0, INIT re-pulses RamInit;
//    Start during INIT is ignored.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - weight RAM fetch sequencer with trainer write-back arbitration
module weight_fetch_ctrl #(
    parameter int WIDTH    = 10,
    parameter int LANES    = 10,
    parameter int DEPTH    = 60,
    parameter int ADDR_W   = 6,
    parameter int NUM_ROWS = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic                    RamInit,
    output logic                    RamWE,
    output logic [ADDR_W-1:0]       RamAddr,
    output logic [LANES*WIDTH-1:0]  RamD,
    input  logic [LANES*WIDTH-1:0]  RamQ,
    output logic                    WValid,
    input  logic                    WReady,
    output logic [2:0]              WRow,
    output logic [LANES*WIDTH-1:0]  WData,
    input  logic                    WrReq,
    input  logic [2:0]              WrRow,
    input  logic [LANES*WIDTH-1:0]  WrData,
    output logic                    WrAck,
    output logic                    WrErr
);

    // Rows that actually fit in the RAM; guards against a NUM_ROWS that overruns DEPTH.
    localparam int ROWS = (NUM_ROWS * LANES <= DEPTH) ? NUM_ROWS : (DEPTH / LANES);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_ISSUE,
        S_RD_VALID,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] row;
    logic [2:0] row_nxt;

    logic last_row;
    logic presenting;
    logic handshake;
    logic wr_window;
    logic wr_bad;
    logic wr_hazard;
    logic wr_take;
    logic wr_do;

    function automatic logic [ADDR_W-1:0] row_base(input logic [2:0] r);
        return ADDR_W'(32'(r) * LANES);
    endfunction

    assign last_row   = (32'(row) == ROWS - 1);
    assign presenting = (state == S_RD_VALID);
    assign handshake  = presenting && WReady;

    // A read issue cycle never grants, so a steady write stream cannot starve the fetch.
    assign wr_window = (state == S_IDLE) || (state == S_RD_VALID) || (state == S_DONE);
    assign wr_bad    = (32'(WrRow) >= ROWS);
    assign wr_hazard = presenting && (WrRow == row);
    assign wr_take   = WrReq && wr_window && !wr_hazard;
    assign wr_do     = wr_take && !wr_bad;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_INIT;
            row   <= 3'd0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        case (state)
            S_INIT: begin
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (Start) begin
                    state_nxt = S_RD_ISSUE;
                    row_nxt   = 3'd0;
                end
            end
            S_RD_ISSUE: begin
                state_nxt = S_RD_VALID;
            end
            S_RD_VALID: begin
                if (handshake) begin
                    if (last_row) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RD_ISSUE;
                        row_nxt   = row + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
                row_nxt   = 3'd0;
            end
        endcase
    end

    // Every output is forced low while Reset is asserted, regardless of state.
    always_comb begin
        Busy    = 1'b0;
        Done    = 1'b0;
        RamInit = 1'b0;
        RamWE   = 1'b0;
        RamAddr = '0;
        RamD    = '0;
        WValid  = 1'b0;
        WRow    = 3'd0;
        WData   = '0;
        WrAck   = 1'b0;
        WrErr   = 1'b0;
        if (!Reset) begin
            case (state)
                S_INIT: begin
                    RamInit = 1'b1;
                end
                S_IDLE: begin
                    RamAddr = '0;
                end
                S_RD_ISSUE: begin
                    Busy    = 1'b1;
                    RamAddr = row_base(row);
                end
                S_RD_VALID: begin
                    Busy    = 1'b1;
                    RamAddr = row_base(row);
                    WValid  = 1'b1;
                    WRow    = row;
                    WData   = RamQ;
                end
                S_DONE: begin
                    Busy = 1'b1;
                    Done = 1'b1;
                end
                default: begin
                    RamAddr = '0;
                end
            endcase

            // Q holds across a write cycle, so the presented row stays stable under a grant.
            if (wr_take) begin
                WrAck = 1'b1;
                WrErr = wr_bad;
            end
            if (wr_do) begin
                RamWE   = 1'b1;
                RamAddr = row_base(WrRow);
                RamD    = WrData;
            end
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb/tb_weight_fetch_ctrl.sv - directed bench for weight_fetch_ctrl with a behavioural weight RAM
module tb_weight_fetch_ctrl;

    localparam int W  = 10;
    localparam int L  = 10;
    localparam int DW = W * L;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Busy;
    logic          Done;
    logic          RamInit;
    logic          RamWE;
    logic [5:0]    RamAddr;
    logic [DW-1:0] RamD;
    logic [DW-1:0] RamQ;
    logic          WValid;
    logic          WReady;
    logic [2:0]    WRow;
    logic [DW-1:0] WData;
    logic          WrReq;
    logic [2:0]    WrRow;
    logic [DW-1:0] WrData;
    logic          WrAck;
    logic          WrErr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    weight_fetch_ctrl dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Busy    (Busy),
        .Done    (Done),
        .RamInit (RamInit),
        .RamWE   (RamWE),
        .RamAddr (RamAddr),
        .RamD    (RamD),
        .RamQ    (RamQ),
        .WValid  (WValid),
        .WReady  (WReady),
        .WRow    (WRow),
        .WData   (WData),
        .WrReq   (WrReq),
        .WrRow   (WrRow),
        .WrData  (WrData),
        .WrAck   (WrAck),
        .WrErr   (WrErr)
    );

    function automatic logic [9:0] default_word(input int a);
        if (a < 10) return (a % 2 == 0) ? 10'h2AA : 10'h155;
        if (a < 20) return 10'h155;
        if (a < 30) return 10'h3E0;
        return 10'h000;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [9:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] alt_row();
        logic [DW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = (i % 2 == 0) ? 10'h2AA : 10'h155;
        return r;
    endfunction

    // Behavioural 60x10b RAM: registered read, write holds Q, init restores defaults.
    logic [9:0] mem [60];
    always @(posedge Clock) begin
        if (RamInit) begin
            for (int i = 0; i < 60; i++) mem[i] <= default_word(i);
        end else if (RamWE) begin
            for (int i = 0; i < L; i++)
                if (int'(RamAddr) + i < 60) mem[int'(RamAddr) + i] <= RamD[i*W +: W];
        end else begin
            for (int i = 0; i < L; i++)
                RamQ[i*W +: W] <= (int'(RamAddr) + i < 60) ? mem[int'(RamAddr) + i] : 10'h000;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic run_pass(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2);
        logic [DW-1:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        WReady = 1'b1;
        Start  = 1'b1;
        #1;
        step();
        Start = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
            check("issue_busy", 128'(Busy), 128'(1));
            check("issue_addr", 128'(RamAddr), 128'(r * 10));
            check("issue_wvalid", 128'(WValid), 128'(0));
            step(); #1;
            check("valid", 128'(WValid), 128'(1));
            check("valid_row", 128'(WRow), 128'(r));
            check("valid_data", 128'(WData), 128'(d[r]));
            step(); #1;
        end
        check("done_pulse", 128'(Done), 128'(1));
        check("done_busy", 128'(Busy), 128'(1));
        step(); #1;
        check("done_end", 128'(Done), 128'(0));
        check("idle_busy", 128'(Busy), 128'(0));
    endtask

    initial begin
        Reset  = 1'b1;
        Start  = 1'b0;
        WReady = 1'b0;
        WrReq  = 1'b0;
        WrRow  = 3'd0;
        WrData = '0;

        // Reset and the single init strobe
        repeat (3) @(posedge Clock);
        #3;
        check("rst_raminit", 128'(RamInit), 128'(0));
        check("rst_busy", 128'(Busy), 128'(0));
        check("rst_wvalid", 128'(WValid), 128'(0));
        Reset = 1'b0;
        #1;
        check("init_pulse", 128'(RamInit), 128'(1));
        check("init_busy", 128'(Busy), 128'(0));
        check("init_wrack", 128'(WrAck), 128'(0));
        check("init_done", 128'(Done), 128'(0));
        step(); #1;
        check("init_once", 128'(RamInit), 128'(0));
        check("idle_addr", 128'(RamAddr), 128'(0));

        // Full pass of default weights
        run_pass(alt_row(), fill(10'h155), fill(10'h3E0));

        // Backpressure on row 1
        WReady = 1'b1;
        Start  = 1'b1;
        #1;
        step(); Start = 1'b0; #1;
        step(); #1;
        step(); #1;
        step(); WReady = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_wvalid", 128'(WValid), 128'(1));
            check("bp_row", 128'(WRow), 128'(1));
            check("bp_addr", 128'(RamAddr), 128'(10));
            check("bp_data", 128'(WData), 128'(fill(10'h155)));
            step(); #1;
        end
        WReady = 1'b1;
        #1;
        check("bp_release", 128'(WValid), 128'(1));
        step(); #1;
        check("bp_next_addr", 128'(RamAddr), 128'(20));
        step(); #1;
        check("bp_row2", 128'(WData), 128'(fill(10'h3E0)));
        step(); #1;
        check("bp_done", 128'(Done), 128'(1));
        step(); #1;

        // Write-back during presentation, plus a same-row hazard
        WReady = 1'b0;
        Start  = 1'b1;
        #1;
        step(); Start = 1'b0; #1;
        step();
        WrReq  = 1'b1;
        WrRow  = 3'd2;
        WrData = fill(10'h3FF);
        #1;
        check("wr_ack", 128'(WrAck), 128'(1));
        check("wr_err", 128'(WrErr), 128'(0));
        check("wr_we", 128'(RamWE), 128'(1));
        check("wr_addr", 128'(RamAddr), 128'(20));
        check("wr_d", 128'(RamD), 128'(fill(10'h3FF)));
        check("wr_keep_valid", 128'(WValid), 128'(1));
        check("wr_keep_data", 128'(WData), 128'(alt_row()));
        step();
        WrRow  = 3'd0;
        WrData = fill(10'h0AB);
        #1;
        check("wr_hold_data", 128'(WData), 128'(alt_row()));
        check("hz_ack", 128'(WrAck), 128'(0));
        check("hz_we", 128'(RamWE), 128'(0));
        check("hz_addr", 128'(RamAddr), 128'(0));
        WReady = 1'b1;
        step(); #1;
        check("hz_issue_ack", 128'(WrAck), 128'(0));
        check("hz_issue_addr", 128'(RamAddr), 128'(10));
        step(); #1;
        check("hz_grant", 128'(WrAck), 128'(1));
        check("hz_grant_we", 128'(RamWE), 128'(1));
        check("hz_grant_addr", 128'(RamAddr), 128'(0));
        check("hz_row1_data", 128'(WData), 128'(fill(10'h155)));
        step();
        WrReq = 1'b0;
        #1;
        step(); #1;
        check("wr_row2_new", 128'(WData), 128'(fill(10'h3FF)));
        step(); #1;
        step(); #1;

        // Out-of-range write row
        WrReq  = 1'b1;
        WrRow  = 3'd5;
        WrData = fill(10'h111);
        #1;
        check("bad_ack", 128'(WrAck), 128'(1));
        check("bad_err", 128'(WrErr), 128'(1));
        check("bad_we", 128'(RamWE), 128'(0));
        step();
        WrReq = 1'b0;
        #1;

        // Reset mid-pass aborts and re-initialises the RAM
        WReady = 1'b1;
        Start  = 1'b1;
        #1;
        step(); Start = 1'b0; #1;
        step(); #1;
        check("new_row0", 128'(WData), 128'(fill(10'h0AB)));
        step(); #1;
        step();
        WReady = 1'b0;
        Reset  = 1'b1;
        #1;
        check("mid_rst_wvalid", 128'(WValid), 128'(0));
        check("mid_rst_busy", 128'(Busy), 128'(0));
        check("mid_rst_wdata", 128'(WData), 128'(0));
        check("mid_rst_addr", 128'(RamAddr), 128'(0));
        step();
        Reset = 1'b0;
        Start = 1'b1;
        #1;
        check("reinit_pulse", 128'(RamInit), 128'(1));
        check("reinit_busy", 128'(Busy), 128'(0));
        step();
        Start = 1'b0;
        #1;
        check("start_ignored", 128'(Busy), 128'(0));
        check("reinit_once", 128'(RamInit), 128'(0));
        run_pass(alt_row(), fill(10'h155), fill(10'h3E0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
